// File: rtl/axi_cfg_regs.sv
`default_nettype none
// ============================================================================
//  Module      : axi_cfg_regs
//  Description : AXI4 slave register bank. Single-beat 32-bit accesses to
//                NUM_REGS read/write control registers followed by NUM_REGS
//                read-only status words sampled from the accelerator.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_cfg_regs #(
  parameter int                    ADDR_WIDTH = 40,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 6,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 40'hA0000000
) (
  input  logic                           clk,
  input  logic                           rstn,
  // write address channel
  input  logic [ID_WIDTH-1:0]            s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [7:0]                     s_axi_awlen,
  input  logic [2:0]                     s_axi_awsize,
  input  logic [1:0]                     s_axi_awburst,
  input  logic                           s_axi_awlock,
  input  logic [3:0]                     s_axi_awcache,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wlast,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  // write response channel
  output logic [ID_WIDTH-1:0]            s_axi_bid,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  // read address channel
  input  logic [ID_WIDTH-1:0]            s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [7:0]                     s_axi_arlen,
  input  logic [2:0]                     s_axi_arsize,
  input  logic [1:0]                     s_axi_arburst,
  input  logic                           s_axi_arlock,
  input  logic [3:0]                     s_axi_arcache,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  // read data channel
  output logic [ID_WIDTH-1:0]            s_axi_rid,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rlast,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  // accelerator side
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] stat_i
);

  localparam int                    c_IDX_W  = $clog2(NUM_REGS);
  localparam int                    c_STRB_W = DATA_WIDTH / 8;
  // RW block followed by RO block, 4 bytes per word
  localparam logic [ADDR_WIDTH-1:0] c_SPAN   = ADDR_WIDTH'(8 * NUM_REGS);
  localparam logic [1:0]            c_OKAY   = 2'b00;
  localparam logic [1:0]            c_SLVERR = 2'b10;

  // register storage and write-side holding state
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_aw_held;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_STRB_W-1:0]   r_wstrb;
  logic                  r_bvalid;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp;
  logic [NUM_REGS-1:0]   r_wr_pulse;

  // read-side response state
  logic                  r_rvalid;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;

  // handshake readiness; all readys forced low while reset is asserted
  logic w_awready, w_wready, w_arready;
  assign w_awready = rstn & ~r_aw_held & ~r_bvalid;
  assign w_wready  = rstn & ~r_w_held  & ~r_bvalid;
  assign w_arready = rstn & ~r_rvalid;

  // write target decode works on the captured address
  logic [ADDR_WIDTH-1:0] w_aw_off;
  logic                  w_aw_inr, w_aw_ro, w_commit, w_wr_ok;
  logic [c_IDX_W-1:0]    w_aw_idx;
  assign w_aw_off = r_awaddr - BASE_ADDR;
  assign w_aw_inr = (r_awaddr >= BASE_ADDR) && (w_aw_off < c_SPAN);
  assign w_aw_ro  = w_aw_off[c_IDX_W+2];
  assign w_aw_idx = w_aw_off[c_IDX_W+1:2];
  assign w_commit = r_aw_held & r_w_held;
  assign w_wr_ok  = w_aw_inr & ~w_aw_ro & (r_awlen == 8'd0);

  // read target decode works on the live AR address
  logic [ADDR_WIDTH-1:0] w_ar_off;
  logic                  w_ar_inr, w_ar_ro, w_rd_ok;
  logic [c_IDX_W-1:0]    w_ar_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  assign w_ar_off = s_axi_araddr - BASE_ADDR;
  assign w_ar_inr = (s_axi_araddr >= BASE_ADDR) && (w_ar_off < c_SPAN);
  assign w_ar_ro  = w_ar_off[c_IDX_W+2];
  assign w_ar_idx = w_ar_off[c_IDX_W+1:2];
  assign w_rd_ok  = w_ar_inr & (s_axi_arlen == 8'd0);

  // read data mux: RW register or status word, zero on error
  always_comb begin
    w_rd_word = '0;
    if (w_rd_ok) begin
      if (w_ar_ro) w_rd_word = stat_i[w_ar_idx*DATA_WIDTH +: DATA_WIDTH];
      else         w_rd_word = r_regs[w_ar_idx];
    end
  end

  // write path: capture AW/W independently, commit once both are held
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_aw_held  <= 1'b0;
      r_awid     <= '0;
      r_awaddr   <= '0;
      r_awlen    <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (s_axi_awvalid && w_awready) begin
        r_aw_held <= 1'b1;
        r_awid    <= s_axi_awid;
        r_awaddr  <= s_axi_awaddr;
        r_awlen   <= s_axi_awlen;
      end
      if (s_axi_wvalid && w_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bid     <= r_awid;
        if (w_wr_ok) begin
          for (int b = 0; b < c_STRB_W; b++) begin
            if (r_wstrb[b]) r_regs[w_aw_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
          end
          r_wr_pulse[w_aw_idx] <= 1'b1;
          r_bresp              <= c_OKAY;
        end else begin
          r_bresp <= c_SLVERR;
        end
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // read path: single beat captured on the AR handshake edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
    end else if (s_axi_arvalid && w_arready) begin
      r_rvalid <= 1'b1;
      r_rid    <= s_axi_arid;
      r_rdata  <= w_rd_word;
      r_rresp  <= w_rd_ok ? c_OKAY : c_SLVERR;
      r_rlast  <= 1'b1;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // flatten register array onto the accelerator bus
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end
  endgenerate

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_arready = w_arready;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rvalid  = r_rvalid;
  assign wr_pulse_o    = r_wr_pulse;

  // attributes accepted on the bus but irrelevant to single-word access
  logic w_unused_inputs;
  assign w_unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_awlock,
                             s_axi_awcache, s_axi_awprot, s_axi_wlast,
                             s_axi_arsize, s_axi_arburst, s_axi_arlock,
                             s_axi_arcache, s_axi_arprot,
                             w_aw_off[1:0], w_ar_off[1:0]};

endmodule
`default_nettype wire
